// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the bus-attached UART transmitter.
//   - register offsets (word index, bus_address[3:2])
//   - STATUS register bit positions
//   - transmitter state enumeration
//   - helper that turns a DIVISOR value into a bit-counter reload value
package uart_pkg;

    // Register offsets as word indices within the 16-byte window
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A bit lasts max(divisor,1) cycles; the down-counter is loaded with
    // one less than that and the bit ends when it reaches zero.
    function automatic logic [15:0] bit_reload(input logic [15:0] divisor);
        return (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clock      - clock
//   reset      - asynchronous active-low reset (empties the FIFO)
//   push       - write request; accepted when not full, or when full and
//                a pop happens in the same cycle
//   push_data  - data written on an accepted push
//   pop        - read request; ignored when empty
//   pop_data   - current head entry (valid whenever empty is low)
//   full/empty - occupancy flags
//   count      - number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    // Storage carries no reset so it can map onto plain RAM
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_uart_responder.sv
// bus_uart_responder: memory-mapped UART transmitter with a transmit FIFO.
// Register window (16 bytes at BASE_ADDRESS):
//   0x0 TXDATA  (W)   byte lane 0 pushes a byte into the FIFO
//   0x4 STATUS  (R)   {count[7:4], overflow, busy, empty, full}
//   0x8 DIVISOR (R/W) clock cycles per bit, byte-enabled writes
//   0xC         (R)   reads zero
// Ports:
//   clock, reset                  - clock, asynchronous active-low reset
//   bus_address/bus_write_data    - initiator address and write data
//   bus_byte_enable               - write byte lanes
//   bus_read_enable/bus_write_enable - single-cycle strobes
//   bus_read_data                 - registered read data, zero when no read
//   uart_tx                       - serial output, idle high
//   tx_irq                        - registered (FIFO empty and transmitter idle)
module bus_uart_responder
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h8000_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       sel, rd_sel, wr_sel;
    logic [1:0] offset;
    logic [1:0] div_lane_we;
    logic       unused_ok;

    // FIFO interface
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    // State
    tx_state_e   state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;

    logic        busy, bit_end;
    logic [15:0] reload;
    logic [31:0] status_word;

    assign sel    = (bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign offset = bus_address[3:2];
    assign rd_sel = sel & bus_read_enable;
    // A read strobe wins over a concurrent write: the write is dropped
    assign wr_sel = sel & bus_write_enable & ~bus_read_enable;

    assign fifo_push = wr_sel & (offset == REG_TXDATA) & bus_byte_enable[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_div_lane
        assign div_lane_we[gi] = wr_sel & (offset == REG_DIVISOR) & bus_byte_enable[gi];
    end

    // Bits of the bus that no register uses
    assign unused_ok = ^{bus_address[1:0], bus_write_data[31:16], bus_byte_enable[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus_write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy    = (state_q != TX_IDLE);
    assign bit_end = (bit_cnt_q == 16'd0);
    // The reload reads the live DIVISOR, so a new divisor only takes effect
    // at the next bit boundary.
    assign reload  = bit_reload(div_q);

    // Transmitter
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        if (busy && !bit_end) begin
            bit_cnt_d = bit_cnt_q - 16'd1;
        end

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    state_d   = TX_START;
                    bit_cnt_d = reload;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    bit_cnt_d = reload;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = reload;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Back-to-back frames: skip IDLE entirely
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_head;
                        state_d   = TX_START;
                        bit_cnt_d = reload;
                    end else begin
                        state_d   = TX_IDLE;
                        bit_cnt_d = 16'd0;
                    end
                end
            end
            default: begin
                state_d   = TX_IDLE;
                bit_cnt_d = 16'd0;
            end
        endcase

        // Line level is registered from the next state to keep uart_tx glitch-free
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Registers, status and read path
    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_EMPTY]    = fifo_empty;
        status_word[STAT_BUSY]     = busy;
        status_word[STAT_OVERFLOW] = ovf_q;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);

        rdata_d = '0;
        if (rd_sel) begin
            case (offset)
                REG_STATUS:  rdata_d = status_word;
                REG_DIVISOR: rdata_d = {16'd0, div_q};
                default:     rdata_d = '0;
            endcase
        end

        // Sticky overflow; a STATUS read clears it unless a new drop
        // happens in the very same cycle.
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (rd_sel && (offset == REG_STATUS)) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        div_d = div_q;
        if (div_lane_we[0]) div_d[7:0]  = bus_write_data[7:0];
        if (div_lane_we[1]) div_d[15:8] = bus_write_data[15:8];

        irq_d = fifo_empty & ~busy;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            bit_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
            rdata_q   <= 32'd0;
            ovf_q     <= 1'b0;
            div_q     <= DEFAULT_DIVISOR;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
        end
    end

    assign bus_read_data = rdata_q;
    assign uart_tx       = tx_q;
    assign tx_irq        = irq_q;

endmodule

// File: tb/tb_bus_uart_responder.sv
// Directed bench for bus_uart_responder with a frame-level reference model
// that is compared against the outputs on every falling clock edge.
module tb_bus_uart_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DEF_DIV = 16'd868;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'd4;
    localparam logic [31:0] A_DIV = BASE + 32'd8;
    localparam logic [31:0] A_RSV = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] bus_read_data;
    logic        uart_tx;
    logic        tx_irq;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_uart_responder #(
        .BASE_ADDRESS    (BASE),
        .FIFO_DEPTH      (DEPTH),
        .DEFAULT_DIVISOR (DEF_DIV)
    ) dut (
        .clock            (clk),
        .reset            (rst_n),
        .bus_address      (addr),
        .bus_write_data   (wdata),
        .bus_byte_enable  (be),
        .bus_read_enable  (re),
        .bus_write_enable (we),
        .bus_read_data    (bus_read_data),
        .uart_tx          (uart_tx),
        .tx_irq           (tx_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is the 10-bit line image {stop, data, start}; the model walks
    // through its positions, each lasting max(divisor,1) clocks.
    logic [7:0]  mq[$];
    bit          m_active = 1'b0;
    int          m_pos = 0;
    int          m_left = 0;
    logic [9:0]  m_frame = '1;
    logic [15:0] m_div = DEF_DIV;
    logic        m_ovf = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_irq = 1'b0;
    logic        m_tx = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        bit          sel, rd, wr, popped, ovf_ev, active0, ovf0;
        logic [1:0]  off;
        int          size0, period;
        logic [15:0] div0;
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0; m_pos = 0; m_left = 0;
            m_div = DEF_DIV; m_ovf = 1'b0; m_rdata = '0; m_irq = 1'b0; m_tx = 1'b1;
        end else begin
            sel = (addr[31:4] == BASE[31:4]);
            off = addr[3:2];
            rd = sel && re;
            wr = sel && we && !re;
            size0 = mq.size(); active0 = m_active; div0 = m_div; ovf0 = m_ovf;
            period = (div0 == 16'd0) ? 1 : int'(div0);
            popped = 1'b0; ovf_ev = 1'b0;

            if (m_active) begin
                if (m_left > 1) m_left--;
                else if (m_pos < 9) begin m_pos++; m_left = period; end
                else m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_frame = {1'b1, mq.pop_front(), 1'b0};
                m_pos = 0; m_left = period; m_active = 1'b1; popped = 1'b1;
            end

            if (wr && off == 2'd0 && be[0]) begin
                if (size0 < DEPTH || popped) mq.push_back(wdata[7:0]);
                else ovf_ev = 1'b1;
            end

            m_rdata = '0;
            if (rd) begin
                if (off == 2'd1)
                    m_rdata = 32'(size0 * 16 + int'(ovf0) * 8 + int'(active0) * 4
                                  + (size0 == 0 ? 2 : 0) + (size0 == DEPTH ? 1 : 0));
                else if (off == 2'd2)
                    m_rdata = {16'd0, div0};
            end

            if (ovf_ev) m_ovf = 1'b1;
            else if (rd && off == 2'd1) m_ovf = 1'b0;

            if (wr && off == 2'd2) begin
                if (be[0]) m_div[7:0]  = wdata[7:0];
                if (be[1]) m_div[15:8] = wdata[15:8];
            end

            m_irq = (size0 == 0) && !active0;
            m_tx  = m_active ? m_frame[m_pos] : 1'b1;
        end
    end

    always @(negedge clk) begin
        check("uart_tx", 32'(uart_tx), 32'(m_tx));
        check("tx_irq", 32'(tx_irq), 32'(m_irq));
        check("rdata", bus_read_data, m_rdata);
    end

    // ---------------- bus tasks (called on a falling edge) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        $display("WR  addr=%08h data=%08h be=%b", a, d, b);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        @(negedge clk);
        d = bus_read_data; re = 1'b0;
        $display("RD  addr=%08h data=%08h", a, d);
    endtask

    task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_irq", 32'(tx_irq), 32'd0);
        check("reset_rdata", bus_read_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("irq_after_release", 32'(tx_irq), 32'd1);
        $display("RST released");
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  f;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("irq_first_edge", 32'(tx_irq), 32'd1);

        // Reset values and simple register behaviour
        read_expect("div_reset", A_DIV, 32'h0000_0364);
        read_expect("status_reset", A_ST, 32'h0000_0002);
        read_expect("reg_c_zero", A_RSV, 32'h0);
        bus_write(A_DIV, 32'h0000_1234, 4'b0001);
        read_expect("div_byte_en", A_DIV, 32'h0000_0334);
        addr = A_DIV; wdata = 32'h0000_AAAA; be = 4'hF; re = 1'b1; we = 1'b1;
        @(negedge clk);
        d = bus_read_data; re = 1'b0; we = 1'b0;
        $display("RW  addr=%08h data=%08h", A_DIV, d);
        check("rw_read_wins", d, 32'h0000_0334);
        read_expect("rw_write_dropped", A_DIV, 32'h0000_0334);
        bus_write(32'h8000_0010, 32'h77, 4'b0001);
        read_expect("outside_window", A_ST, 32'h0000_0002);

        // DIVISOR=4, byte 0x55
        bus_write(A_DIV, 32'd4, 4'b0011);
        bus_write(A_TX, 32'h55, 4'b0001);
        f = 10'b1010101010;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("s1_line", 32'(uart_tx), 32'(f[k / 4]));
        end
        repeat (2) @(negedge clk);
        read_expect("s1_status_idle", A_ST, 32'h0000_0002);
        check("s1_irq", 32'(tx_irq), 32'd1);

        // DIVISOR=0: one-cycle bits, byte 0x0F
        bus_write(A_DIV, 32'd0, 4'b0011);
        bus_write(A_TX, 32'h0F, 4'b0001);
        f = 10'b1000011110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("s4_line", 32'(uart_tx), 32'(f[k]));
        end
        @(negedge clk);
        check("s4_done_tx", 32'(uart_tx), 32'd1);
        repeat (2) @(negedge clk);

        // Divisor change mid-START: START 4 cycles, first data bit 8 cycles
        bus_write(A_DIV, 32'd4, 4'b0011);
        bus_write(A_TX, 32'h01, 4'b0001);
        @(negedge clk);
        check("s5_start0", 32'(uart_tx), 32'd0);
        bus_write(A_DIV, 32'd8, 4'b0011);
        check("s5_start1", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("s5_start", 32'(uart_tx), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("s5_bit0", 32'(uart_tx), 32'd1);
        end
        @(negedge clk);
        check("s5_bit1", 32'(uart_tx), 32'd0);
        repeat (70) @(negedge clk);
        do_reset();

        // 9 back-to-back writes: all kept
        bus_write(A_DIV, 32'd1000, 4'b0011);
        for (int k = 1; k <= 9; k++) bus_write(A_TX, 32'(k), 4'b0001);
        read_expect("s2_status", A_ST, 32'h0000_0085);
        check("s2_irq", 32'(tx_irq), 32'd0);
        do_reset();

        // 10 back-to-back writes: the last is dropped
        bus_write(A_DIV, 32'd1000, 4'b0011);
        for (int k = 1; k <= 10; k++) bus_write(A_TX, 32'(k), 4'b0001);
        read_expect("s3_status_ovf", A_ST, 32'h0000_008D);
        read_expect("s3_status_clr", A_ST, 32'h0000_0085);
        do_reset();

        // Reset during DATA of 0xA5
        bus_write(A_DIV, 32'd4, 4'b0011);
        bus_write(A_TX, 32'hA5, 4'b0001);
        repeat (9) @(negedge clk);
        check("s6_mid_data", 32'(uart_tx), 32'd0);
        do_reset();
        read_expect("s6_status", A_ST, 32'h0000_0002);
        check("s6_irq", 32'(tx_irq), 32'd1);
        repeat (60) @(negedge clk);
        check("s6_no_resume", 32'(uart_tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
